// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl
// Session controller for a 4-member majority voter. Opens a voting window,
// collects one ballot per member over a valid/ready handshake, presents the
// registered ballot vector to the voter, samples and encodes the voter's
// one-hot verdict, and reports it downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   start             one-cycle pulse opening a session (honoured in IDLE only)
//   ballot_valid/_id/_yes, ballot_ready   ballot input handshake
//   ballot_vec        registered ballots to voter, bit k = member k voted yes
//   verdict_in        voter one-hot verdict (001 reject, 010 tie, 100 pass)
//   result_valid/_ready, result_code      result output handshake
//                     (00 reject, 01 tie, 10 pass, 11 illegal verdict)
//   yes_count, abstain_mask, dup_seen, timed_out   session statistics
//   busy              high whenever the controller is not IDLE
module vote_session_ctrl #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ballot_valid,
  input  logic [1:0] ballot_id,
  input  logic       ballot_yes,
  output logic       ballot_ready,
  output logic [3:0] ballot_vec,
  input  logic [2:0] verdict_in,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [1:0] result_code,
  output logic [2:0] yes_count,
  output logic [3:0] abstain_mask,
  output logic       dup_seen,
  output logic       timed_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    REPORT  = 2'd3
  } state_t;

  // Timer value on the last COLLECT cycle of the window.
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [3:0]       mask_q;
  logic [3:0]       vec_q;
  logic [2:0]       yes_cnt_q;
  logic [3:0]       abstain_q;
  logic             dup_q;
  logic             tmo_q;
  logic [1:0]       code_q;
  logic             rvalid_q;
  logic [CNT_W-1:0] timer_q;

  logic [3:0] id_onehot;
  logic [3:0] mask_d;
  logic       is_dup;
  logic [1:0] code_d;

  always_comb begin
    id_onehot = 4'b0001 << ballot_id;
    is_dup    = ballot_valid && ((mask_q & id_onehot) != 4'b0000);
    // Mask as it will be after this cycle's ballot, used to detect completion
    // on the same edge that accepts the final ballot.
    mask_d    = mask_q;
    if (ballot_valid) begin
      mask_d = mask_q | id_onehot;
    end
    case (verdict_in)
      3'b001:  code_d = 2'b00;
      3'b010:  code_d = 2'b01;
      3'b100:  code_d = 2'b10;
      default: code_d = 2'b11;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= 4'b0000;
      vec_q     <= 4'b0000;
      yes_cnt_q <= 3'd0;
      abstain_q <= 4'b0000;
      dup_q     <= 1'b0;
      tmo_q     <= 1'b0;
      code_q    <= 2'b00;
      rvalid_q  <= 1'b0;
      timer_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= COLLECT;
            mask_q    <= 4'b0000;
            vec_q     <= 4'b0000;
            yes_cnt_q <= 3'd0;
            abstain_q <= 4'b0000;
            dup_q     <= 1'b0;
            tmo_q     <= 1'b0;
            code_q    <= 2'b00;
            timer_q   <= '0;
          end
        end

        COLLECT: begin
          timer_q <= timer_q + 1'b1;
          if (ballot_valid) begin
            if (is_dup) begin
              // Repeat ballot: accepted on the handshake but discarded.
              dup_q <= 1'b1;
            end else begin
              mask_q[ballot_id] <= 1'b1;
              vec_q[ballot_id]  <= ballot_yes;
              if (ballot_yes) begin
                yes_cnt_q <= yes_cnt_q + 3'd1;
              end
            end
          end
          // A completing ballot wins over a coincident timeout.
          if (mask_d == 4'b1111) begin
            state_q <= DECIDE;
          end else if (timer_q == LAST_TICK) begin
            state_q <= DECIDE;
            tmo_q   <= 1'b1;
          end
        end

        DECIDE: begin
          // ballot_vec has been stable for this whole cycle, so the voter
          // output is settled by the end of it.
          code_q    <= code_d;
          abstain_q <= ~mask_q;
          rvalid_q  <= 1'b1;
          state_q   <= REPORT;
        end

        REPORT: begin
          if (result_ready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign ballot_ready = (state_q == COLLECT);
  assign busy         = (state_q != IDLE);
  assign ballot_vec   = vec_q;
  assign result_valid = rvalid_q;
  assign result_code  = code_q;
  assign yes_count    = yes_cnt_q;
  assign abstain_mask = abstain_q;
  assign dup_seen     = dup_q;
  assign timed_out    = tmo_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
module tb_vote_session_ctrl;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ballot_valid;
  logic [1:0] ballot_id;
  logic       ballot_yes;
  logic       ballot_ready;
  logic [3:0] ballot_vec;
  logic [2:0] verdict_in;
  logic       result_valid;
  logic       result_ready;
  logic [1:0] result_code;
  logic [2:0] yes_count;
  logic [3:0] abstain_mask;
  logic       dup_seen;
  logic       timed_out;
  logic       busy;
  logic       force_ill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vote_session_ctrl #(.CNT_W(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ballot_valid(ballot_valid), .ballot_id(ballot_id), .ballot_yes(ballot_yes),
    .ballot_ready(ballot_ready), .ballot_vec(ballot_vec), .verdict_in(verdict_in),
    .result_valid(result_valid), .result_ready(result_ready), .result_code(result_code),
    .yes_count(yes_count), .abstain_mask(abstain_mask), .dup_seen(dup_seen),
    .timed_out(timed_out), .busy(busy)
  );

  // Behavioural 4-member majority voter.
  function automatic logic [2:0] voter(input logic [3:0] v);
    int n = $countones(v);
    if (n > 2) return 3'b100;
    if (n == 2) return 3'b010;
    return 3'b001;
  endfunction

  assign verdict_in = force_ill ? 3'b011 : voter(ballot_vec);

  // One session: ballot offered in COLLECT cycle c when v[c] is set.
  typedef struct {
    logic [7:0]  v;
    logic [15:0] ids;
    logic [7:0]  ys;
    logic        ill;
    int          hold;
    logic [3:0]  vec;
    logic [1:0]  code;
    logic [2:0]  yc;
    logic [3:0]  abst;
    logic        dup;
    logic        tmo;
    int          exit_c;
  } sess_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference outcome from the session rules, one ballot slot at a time.
  function automatic sess_t model(input sess_t s);
    sess_t r = s;
    logic [3:0] m = 4'b0000;
    int yc = 0;
    r.vec = 4'b0000; r.dup = 1'b0; r.tmo = 1'b0; r.exit_c = TMO - 1;
    for (int c = 0; c < TMO; c++) begin
      if (s.v[c]) begin
        int k = int'(s.ids[2*c +: 2]);
        if (m[k]) r.dup = 1'b1;
        else begin
          m[k] = 1'b1;
          r.vec[k] = s.ys[c];
          yc += int'(s.ys[c]);
        end
      end
      if (m == 4'hF) begin r.exit_c = c; break; end
      if (c == TMO - 1) r.tmo = 1'b1;
    end
    r.yc = 3'(yc);
    r.abst = ~m;
    r.code = s.ill ? 2'b11 : (yc >= 3 ? 2'b10 : (yc == 2 ? 2'b01 : 2'b00));
    return r;
  endfunction

  task automatic check_fields(input sess_t e, input string tag);
    chk({tag, " result_code"}, result_code, e.code);
    chk({tag, " ballot_vec"}, ballot_vec, e.vec);
    chk({tag, " yes_count"}, yes_count, e.yc);
    chk({tag, " abstain_mask"}, abstain_mask, e.abst);
    chk({tag, " dup_seen"}, dup_seen, e.dup);
    chk({tag, " timed_out"}, timed_out, e.tmo);
  endtask

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic run_session(input sess_t e, input string tag);
    int edges = 0;
    force_ill = e.ill;
    result_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy@collect"}, busy, 1'b1);
    chk({tag, " ready@collect"}, ballot_ready, 1'b1);
    chk({tag, " vec cleared"}, ballot_vec, 4'b0000);
    chk({tag, " yes cleared"}, yes_count, 3'd0);
    while (!result_valid && edges < 40) begin
      ballot_valid = (edges < 8) ? e.v[edges] : 1'b0;
      ballot_id    = (edges < 8) ? e.ids[2*edges +: 2] : 2'd0;
      ballot_yes   = (edges < 8) ? e.ys[edges] : 1'b0;
      @(posedge clk); #1;
      edges++;
      if (edges == e.exit_c + 1) chk({tag, " ready@decide"}, ballot_ready, 1'b0);
    end
    ballot_valid = 1'b0;
    chk({tag, " latency"}, edges, e.exit_c + 2);
    check_fields(e, tag);
    for (int h = 0; h < e.hold; h++) begin
      start = h[0];
      @(posedge clk); #1;
      chk({tag, " hold valid"}, result_valid, 1'b1);
      check_fields(e, {tag, " hold"});
    end
    start = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " valid after hs"}, result_valid, 1'b0);
    chk({tag, " idle after hs"}, busy, 1'b0);
    start = 1'b0;
    result_ready = 1'b0;
    @(posedge clk); #1;
    chk({tag, " start on hs ignored"}, busy, 1'b0);
    chk({tag, " code kept"}, result_code, e.code);
    $display("session %s: code=%b vec=%b yes=%0d abst=%b dup=%b tmo=%b", tag,
             result_code, ballot_vec, yes_count, abstain_mask, dup_seen, timed_out);
    force_ill = 1'b0;
  endtask

  sess_t tbl[7];

  initial begin
    //        v           ids(slot7..0)          ys           ill hold vec     code   yc    abst     dup  tmo exit
    tbl[0] = '{8'h0F, 16'b0000000011100100, 8'b00001111, 1'b0, 0, 4'b1111, 2'b10, 3'd4, 4'b0000, 1'b0, 1'b0, 3};
    tbl[1] = '{8'h0F, 16'b0000000011100100, 8'b00000101, 1'b0, 0, 4'b0101, 2'b01, 3'd2, 4'b0000, 1'b0, 1'b0, 3};
    tbl[2] = '{8'h01, 16'b0000000000000010, 8'b00000001, 1'b0, 0, 4'b0100, 2'b00, 3'd1, 4'b1011, 1'b0, 1'b1, 7};
    tbl[3] = '{8'h1F, 16'b0000001110000101, 8'b00001101, 1'b0, 5, 4'b0111, 2'b10, 3'd3, 4'b0000, 1'b1, 1'b0, 4};
    tbl[4] = '{8'h0F, 16'b0000000011100100, 8'b00000000, 1'b0, 1, 4'b0000, 2'b00, 3'd0, 4'b0000, 1'b0, 1'b0, 3};
    tbl[5] = '{8'h87, 16'b1100000000100100, 8'b10000011, 1'b0, 0, 4'b1011, 2'b10, 3'd3, 4'b0000, 1'b0, 1'b0, 7};
    tbl[6] = '{8'h0F, 16'b0000000011100100, 8'b00001111, 1'b1, 0, 4'b1111, 2'b11, 3'd4, 4'b0000, 1'b0, 1'b0, 3};

    rst_n = 1'b0; start = 1'b0; ballot_valid = 1'b0; ballot_id = 2'd0;
    ballot_yes = 1'b0; result_ready = 1'b0; force_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 1'b0);
    chk("reset ready", ballot_ready, 1'b0);
    chk("reset valid", result_valid, 1'b0);
    chk("reset vec", ballot_vec, 4'b0000);
    chk("reset abst", abstain_mask, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_session(tbl[i], $sformatf("tbl%0d", i));

    // Reset in the middle of COLLECT after two ballots.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ballot_valid = 1'b1; ballot_id = 2'd0; ballot_yes = 1'b1;
    @(posedge clk); #1;
    ballot_id = 2'd1;
    @(posedge clk); #1;
    ballot_valid = 1'b0;
    chk("pre-reset yes_count", yes_count, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst ready", ballot_ready, 1'b0);
    chk("async rst vec", ballot_vec, 4'b0000);
    chk("async rst yes", yes_count, 3'd0);
    chk("async rst flags", {result_valid, result_code, abstain_mask, dup_seen, timed_out}, 9'd0);
    $display("mid-session reset applied");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_session(tbl[0], "post-reset");

    // Randomized sessions against the reference model.
    for (int n = 0; n < 30; n++) begin
      sess_t s;
      s.v    = 8'($urandom);
      s.ids  = 16'($urandom);
      s.ys   = 8'($urandom);
      s.ill  = ($urandom_range(0, 7) == 0);
      s.hold = $urandom_range(0, 3);
      s = model(s);
      run_session(s, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
Session controller for the 4-member majority voter. It opens a voting window, collects one ballot per member over a valid/ready handshake, and drives the registered 4-bit ballot vector into the voter. It then samples the voter's one-hot verdict (001 reject, 010 tie, 100 pass), encodes it, and reports it downstream with a valid/ready handshake. It sits between the member-input front end and the voter, on the voter's input side and its output side.

Parameters:
TIMEOUT_CYCLES, 255, COLLECT cycles allowed before the window closes; legal range 1..2^CNT_W-1.
CNT_W, 8, width of the window timer.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that opens a session; honoured only in IDLE
ballot_valid  in  1  ballot offered
ballot_id  in  2  member index 0..3
ballot_yes  in  1  1 = yes, 0 = no
ballot_ready  out  1  ballot accepted when valid & ready
ballot_vec  out  4  registered ballots to voter input; bit k = member k yes
verdict_in  in  3  voter one-hot output
result_valid  out  1  result available
result_ready  in  1  downstream accepts result
result_code  out  2  00 reject, 01 tie, 10 pass, 11 illegal verdict
yes_count  out  3  number of yes ballots, 0..4
abstain_mask  out  4  bit k = member k cast no ballot
dup_seen  out  1  a repeat ballot arrived this session
timed_out  out  1  window closed by timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. On reset, every output and internal register goes to 0, state = IDLE. abstain_mask resets to 0.
- States: IDLE, COLLECT, DECIDE, REPORT. State is encoded in a register; all outputs come from registers except ballot_ready and busy, which decode state.
- IDLE: ballot_ready=0. On start, go to COLLECT and, in the same edge, clear ballot_vec, cast mask, yes_count, dup_seen, timed_out, result_code and timer.
- COLLECT: ballot_ready=1 and the timer increments every cycle.
  - Accepting a ballot from member id with mask[id]=0 sets mask[id], sets ballot_vec[id]=ballot_yes, and increments yes_count if ballot_yes.
  - If mask[id]=1, the ballot is still accepted (ready stays high) but ignored, and dup_seen is set (sticky until the next start).
  - Exit to DECIDE on the edge where the accepted ballot completes the mask to 1111, or on the edge where timer = TIMEOUT_CYCLES-1. On a timeout exit, timed_out=1.
  - If the final ballot and the timeout coincide, the ballot is accepted and timed_out=0.
- Absent members count as no, so ballot_vec bit stays 0.
- DECIDE: lasts exactly one cycle; ballot_vec is stable and the voter settles combinationally. At the end of the cycle, sample verdict_in: 001->00, 010->01, 100->10, anything else->11. Also register abstain_mask = ~mask. Go to REPORT.
- REPORT: result_valid=1; result_code, yes_count, abstain_mask, dup_seen and timed_out are held stable. On result_valid & result_ready, go to IDLE with result_valid=0 on the next cycle. The result fields keep their values until the next start.
- start is ignored outside IDLE. start arriving on the same cycle as the REPORT handshake is ignored.
- Latency: if the 4th ballot is accepted at edge t, result_valid is high at cycle t+2. With result_ready tied high, the next start is honoured at t+3.
- ballot_vec changes only in COLLECT or at start.
- Reset mid-session: immediate return to IDLE with all outputs 0; the partial ballot is lost.

Test Plan:
- start; ballots (0,1),(1,1),(2,1),(3,1) back-to-back; result_ready=1 -> ballot_vec=1111, result_code=10, yes_count=4, result_valid two cycles after last ballot, abstain_mask=0000.
- Ballots (0,1),(1,0),(2,1),(3,0) -> ballot_vec=0101, result_code=01, yes_count=2.
- TIMEOUT_CYCLES=8; only ballot (2,1) -> DECIDE after 8 COLLECT cycles, timed_out=1, ballot_vec=0100, result_code=00, abstain_mask=1011.
- Ballots (1,1),(1,0),(0,1),(2,1),(3,0) -> second id-1 ballot ignored, dup_seen=1, ballot_vec=0111, result_code=10, yes_count=3.
- result_ready held low 5 cycles in REPORT -> result_valid and all fields stable throughout; start pulses are ignored; IDLE is entered the cycle after result_ready rises.
- Force verdict_in=011 in DECIDE -> result_code=11. rst_n low mid-COLLECT after 2 ballots -> all outputs 0 asynchronously; a fresh start then gives a clean session.
